median_frame_ctrl: RTL and testbench

Frame sequencer for the serial 3x3 MEDIAN filter. For every pixel of a square 2^N x 2^N 8-bit image held in a synchronous-read memory, it fetches the 3x3 neighbourhood with edge clamping and streams the nine samples to MEDIAN on DI/DSI. It then waits for DSO and writes DO to a result memory at the same pixel address. It sits between the image buffers and the MEDIAN instance and replaces the software windowing loop used for whole-frame filtering.

---
 rtl/median_pkg.sv | 33 +++
 rtl/median_win_addr.sv | 42 ++++
 rtl/median_frame_ctrl.sv | 122 ++++++++++++
 tb/tb_median_frame_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and tap-offset helpers for the median frame sequencer
package median_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int NTAPS = 9;

    localparam logic signed [1:0] OFF_NEG  = -2'sd1;
    localparam logic signed [1:0] OFF_ZERO = 2'sd0;
    localparam logic signed [1:0] OFF_POS  = 2'sd1;

    // Row offset of tap k: rows -1, 0, +1 in groups of three taps
    function automatic logic signed [1:0] tap_row_off(input logic [3:0] k);
        if (k < 4'd3)      return OFF_NEG;
        else if (k < 4'd6) return OFF_ZERO;
        else               return OFF_POS;
    endfunction

    // Column offset of tap k: columns -1, 0, +1 repeating within each row
    function automatic logic signed [1:0] tap_col_off(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: return OFF_NEG;
            4'd1, 4'd4, 4'd7: return OFF_ZERO;
            default:          return OFF_POS;
        endcase
    endfunction

endpackage

// File: rtl/median_win_addr.sv
// rtl/median_win_addr.sv - clamped 3x3 window read address for pixel (x,y), tap k
module median_win_addr
    import median_pkg::*;
#(
    parameter int WIDTH_LOG2 = 8
) (
    input  logic [WIDTH_LOG2-1:0]   i_x,
    input  logic [WIDTH_LOG2-1:0]   i_y,
    input  logic [3:0]              i_k,
    output logic [2*WIDTH_LOG2-1:0] o_addr
);

    // Two spare bits: one for the sign, one so that (W-1)+1 stays positive
    localparam int SW = WIDTH_LOG2 + 2;
    localparam logic signed [SW-1:0] C_MAX = SW'((1 << WIDTH_LOG2) - 1);

    logic signed [1:0]      w_drow;
    logic signed [1:0]      w_dcol;
    logic signed [SW-1:0]   w_sx;
    logic signed [SW-1:0]   w_sy;
    logic [WIDTH_LOG2-1:0]  w_rx;
    logic [WIDTH_LOG2-1:0]  w_ry;

    // Offset the pixel coordinates by the tap offsets and clamp to the image edges
    always_comb begin
        w_drow = tap_row_off(i_k);
        w_dcol = tap_col_off(i_k);
        w_sx   = $signed({2'b00, i_x}) + $signed({{WIDTH_LOG2{w_dcol[1]}}, w_dcol});
        w_sy   = $signed({2'b00, i_y}) + $signed({{WIDTH_LOG2{w_drow[1]}}, w_drow});

        if (w_sx < 0)           w_rx = '0;
        else if (w_sx > C_MAX)  w_rx = C_MAX[WIDTH_LOG2-1:0];
        else                    w_rx = w_sx[WIDTH_LOG2-1:0];

        if (w_sy < 0)           w_ry = '0;
        else if (w_sy > C_MAX)  w_ry = C_MAX[WIDTH_LOG2-1:0];
        else                    w_ry = w_sy[WIDTH_LOG2-1:0];
    end

    assign o_addr = {w_ry, w_rx};

endmodule

// File: rtl/median_frame_ctrl.sv
// rtl/median_frame_ctrl.sv - whole-frame 3x3 window sequencer feeding a serial median unit
module median_frame_ctrl
    import median_pkg::*;
#(
    parameter int WIDTH_LOG2 = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [2*WIDTH_LOG2-1:0] o_raddr,
    input  logic [7:0]              i_rdata,
    output logic [7:0]              o_mdi,
    output logic                    o_mdsi,
    input  logic [7:0]              i_mdo,
    input  logic                    i_mdso,
    output logic [2*WIDTH_LOG2-1:0] o_waddr,
    output logic [7:0]              o_wdata,
    output logic                    o_we
);

    localparam int AW = 2 * WIDTH_LOG2;
    localparam logic [WIDTH_LOG2-1:0] C_EDGE  = '1;
    localparam logic [3:0]            C_KLAST = 4'(NTAPS - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [WIDTH_LOG2-1:0]  r_x;
    logic [WIDTH_LOG2-1:0]  r_y;
    logic [3:0]             r_k;
    logic                   r_mdsi;
    logic                   r_done;
    logic [AW-1:0]          r_waddr;
    logic [7:0]             r_wdata;
    logic                   w_last_pix;
    logic                   w_tap_end;

    assign w_last_pix = (r_x == C_EDGE) && (r_y == C_EDGE);
    assign w_tap_end  = (r_k == C_KLAST);

    median_win_addr #(
        .WIDTH_LOG2 (WIDTH_LOG2)
    ) u_win_addr (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_k    (r_k),
        .o_addr (o_raddr)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state: nine fetch taps, wait for the median, one write per pixel
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start)   w_next = FETCH;
            FETCH:   if (w_tap_end) w_next = WAIT;
            WAIT:    if (i_mdso)    w_next = WRITE;
            WRITE:   w_next = w_last_pix ? IDLE : FETCH;
            default: w_next = IDLE;
        endcase
    end

    // Decoded outputs
    always_comb begin
        o_we   = (r_state == WRITE);
        o_busy = (r_state != IDLE);
    end

    // Pixel/tap counters, sample strobe, result register and done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_k     <= '0;
            r_mdsi  <= 1'b0;
            r_done  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            // One-cycle delay lines the strobe up with the synchronous-read data
            r_mdsi <= (r_state == FETCH);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_x <= '0;
                        r_y <= '0;
                        r_k <= '0;
                    end
                end
                FETCH: begin
                    r_k <= w_tap_end ? 4'd0 : r_k + 4'd1;
                end
                WAIT: begin
                    if (i_mdso) begin
                        r_wdata <= i_mdo;
                        r_waddr <= {r_y, r_x};
                    end
                end
                WRITE: begin
                    r_x <= r_x + 1'b1;
                    if (r_x == C_EDGE) r_y <= r_y + 1'b1;
                    if (w_last_pix)    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_mdi   = i_rdata;
    assign o_mdsi  = r_mdsi;
    assign o_done  = r_done;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb/tb_median_frame_ctrl.sv - randomized self-checking bench for median_frame_ctrl
module tb_median_frame_ctrl;

    localparam int WL    = 2;
    localparam int W     = 1 << WL;
    localparam int NPIX  = W * W;
    localparam int AW    = 2 * WL;
    localparam int STALL = 20;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_start;
    logic           o_busy;
    logic           o_done;
    logic [AW-1:0]  o_raddr;
    logic [7:0]     ram_q;
    logic [7:0]     o_mdi;
    logic           o_mdsi;
    logic [7:0]     i_mdo;
    logic           i_mdso;
    logic [AW-1:0]  o_waddr;
    logic [7:0]     o_wdata;
    logic           o_we;

    always #5 clk = ~clk;

    median_frame_ctrl #(.WIDTH_LOG2(WL)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_raddr (o_raddr),
        .i_rdata (ram_q),
        .o_mdi   (o_mdi),
        .o_mdsi  (o_mdsi),
        .i_mdo   (i_mdo),
        .i_mdso  (i_mdso),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_we    (o_we)
    );

    logic [7:0] img [NPIX];
    always @(posedge clk) ram_q <= img[o_raddr];

    int         exp_taps  [NPIX][9];
    logic [7:0] exp_frame [NPIX];
    int         n_cmp = 0;
    int         n_fail = 0;

    int  wr_idx, tap_pix, tap_k, run, gap, done_cnt;
    logic [AW-1:0] prev_raddr;
    logic prev_mdsi;
    bit  stall_mode = 0;
    bit  spur_en = 0;
    int  med_delay = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > W - 1) return W - 1;
        return v;
    endfunction

    // Median by rank counting: the value with at most 4 smaller and at least 5 not larger
    function automatic logic [7:0] median_rank(input logic [7:0] s [9]);
        for (int i = 0; i < 9; i++) begin
            int lt = 0;
            int le = 0;
            for (int j = 0; j < 9; j++) begin
                if (s[j] < s[i])  lt++;
                if (s[j] <= s[i]) le++;
            end
            if (lt <= 4 && le >= 5) return s[i];
        end
        return 8'h00;
    endfunction

    // Median by bubble sort, used by the MEDIAN stand-in
    function automatic logic [7:0] median_sort(input logic [7:0] s [9]);
        logic [7:0] t [9];
        logic [7:0] tmp;
        t = s;
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8 - a; b++)
                if (t[b] > t[b+1]) begin
                    tmp = t[b]; t[b] = t[b+1]; t[b+1] = tmp;
                end
        return t[4];
    endfunction

    task automatic build_model();
        logic [7:0] s [9];
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++) begin
                for (int k = 0; k < 9; k++) begin
                    int ry = clampi(y + k / 3 - 1);
                    int rx = clampi(x + k % 3 - 1);
                    exp_taps[y*W+x][k] = ry * W + rx;
                    s[k] = img[ry*W+rx];
                end
                exp_frame[y*W+x] = median_rank(s);
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    // MEDIAN stand-in: collects nine samples, answers after med_delay cycles
    initial begin
        logic [7:0] sbuf [9];
        logic [7:0] med;
        int scnt = 0;
        int pend = 0;
        i_mdso = 1'b0;
        i_mdo  = 8'h00;
        med    = 8'h00;
        forever begin
            @(negedge clk);
            i_mdso = 1'b0;
            if (!rst_n) begin
                scnt = 0;
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        i_mdso = 1'b1;
                        i_mdo  = med;
                    end
                end
                if (o_mdsi) begin
                    if (spur_en && scnt == 3) begin
                        i_mdso = 1'b1;
                        i_mdo  = 8'hEE;
                    end
                    sbuf[scnt] = o_mdi;
                    scnt++;
                    if (scnt == 9) begin
                        med  = median_sort(sbuf);
                        pend = med_delay;
                        scnt = 0;
                    end
                end
            end
        end
    end

    // Cycle checker: tap addresses, strobe length, write order/data, done
    initial begin
        prev_mdsi = 1'b0;
        prev_raddr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_mdsi = 1'b0;
                run = 0;
            end else begin
                if (o_mdsi) begin
                    if (!prev_mdsi) check("window_after_write", wr_idx, tap_pix);
                    if (tap_pix < NPIX) check("raddr", prev_raddr, exp_taps[tap_pix][tap_k]);
                    else                check("extra_window", tap_pix, NPIX - 1);
                    tap_k++;
                    run++;
                    if (tap_k == 9) begin
                        tap_k = 0;
                        tap_pix++;
                    end
                end else if (prev_mdsi) begin
                    check("mdsi_run", run, 9);
                    run = 0;
                end
                if (o_we) begin
                    check("we_after_mdso", i_mdso, 1);
                    check("busy_with_we", o_busy, 1);
                    check("we_after_window", tap_pix, wr_idx + 1);
                    if (stall_mode) check("stall_gap", gap >= STALL, 1);
                    if (wr_idx < NPIX) begin
                        check("waddr", o_waddr, wr_idx);
                        check("wdata", o_wdata, exp_frame[wr_idx]);
                    end else begin
                        check("extra_write", wr_idx, NPIX - 1);
                    end
                    wr_idx++;
                end
                if (o_done) begin
                    done_cnt++;
                    check("done_after_last", wr_idx, NPIX);
                    check("busy_at_done", o_busy, 0);
                end
                gap = o_mdsi ? 0 : gap + 1;
                prev_mdsi = o_mdsi;
            end
            prev_raddr = o_raddr;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_raddr"}, o_raddr, 0);
        check({tag, "_mdsi"},  o_mdsi, 0);
        check({tag, "_waddr"}, o_waddr, 0);
        check({tag, "_wdata"}, o_wdata, 0);
        check({tag, "_we"},    o_we, 0);
        check({tag, "_busy"},  o_busy, 0);
        check({tag, "_done"},  o_done, 0);
    endtask

    task automatic start_frame();
        @(negedge clk);
        wr_idx = 0; tap_pix = 0; tap_k = 0; run = 0; gap = 0; done_cnt = 0;
        check("busy_before_start", o_busy, 0);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_t1", o_busy, 1);
        check("mdsi_t1", o_mdsi, 0);
        check("raddr_t1", o_raddr, exp_taps[0][0]);
        i_start = 1'b0;
        @(posedge clk);
        #1;
        check("mdsi_t2", o_mdsi, 1);
    endtask

    task automatic run_frame(input bit extra_starts);
        start_frame();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            i_start = extra_starts && (wr_idx < NPIX - 2) && ((cyc % 23) == 7);
            @(posedge clk);
            #2;
            if (done_cnt > 0) break;
        end
        @(negedge clk);
        i_start = 1'b0;
        check("frame_done_seen", done_cnt > 0, 1);
        repeat (5) @(posedge clk);
        #2;
        check("done_pulses", done_cnt, 1);
        check("frame_writes", wr_idx, NPIX);
        check("busy_after_frame", o_busy, 0);
    endtask

    initial begin
        int bad;
        int tap_p0  [9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
        int tap_p15 [9] = '{10, 11, 11, 14, 15, 15, 14, 15, 15};
        rst_n = 1'b0;
        i_start = 1'b0;
        wr_idx = 0; tap_pix = 0; tap_k = 0; run = 0; gap = 0; done_cnt = 0;
        for (int i = 0; i < NPIX; i++) img[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (o_we || o_busy || o_mdsi) bad++;
        end
        check("idle_quiet", bad, 0);

        // Random image, tap order pinned by literals
        fill_random();
        build_model();
        for (int k = 0; k < 9; k++) begin
            check("model_taps_p0", exp_taps[0][k], tap_p0[k]);
            check("model_taps_p15", exp_taps[15][k], tap_p15[k]);
        end
        run_frame(1'b0);

        // Constant image
        for (int i = 0; i < NPIX; i++) img[i] = 8'h55;
        build_model();
        for (int i = 0; i < NPIX; i++) check("model_const", exp_frame[i], 8'h55);
        run_frame(1'b0);

        // Impulse is removed by the median
        for (int i = 0; i < NPIX; i++) img[i] = 8'h10;
        img[5] = 8'hFF;
        build_model();
        for (int i = 0; i < NPIX; i++) check("model_impulse", exp_frame[i], 8'h10);
        run_frame(1'b0);

        // Slow median with early spurious MDSO, START pulses while busy
        med_delay = STALL;
        spur_en = 1;
        stall_mode = 1;
        fill_random();
        build_model();
        run_frame(1'b1);
        med_delay = 1;
        spur_en = 0;
        stall_mode = 0;

        // Reset in the middle of pixel 6's fetch, then a fresh noisy frame
        fill_random();
        build_model();
        start_frame();
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(posedge clk);
            #2;
            if (tap_pix == 6 && tap_k == 3) break;
        end
        check("reached_pixel6", tap_pix, 6);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        build_model();
        run_frame(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
